// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM state codes, port selects,
// the latched request record and the round-robin grant rule.
package mem_responder_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // The word index is kept outside this record because its width follows ADDR_WIDTH.
    typedef struct packed {
        logic        port;
        logic        we;
        logic        rd;
        logic [31:0] wdata;
    } req_t;

    // Fetch is always pending, so data wins unless it held the previous grant.
    function automatic logic grant_data(input logic data_pending, input logic last_was_data);
        return data_pending & ~last_was_data;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core-side bus of the memory responder: one fetch port and one data port.
interface mem_responder_if;

    logic [31:0] pcIn;
    logic [31:0] instrOut;
    logic        ifValid;
    logic [31:0] dataAddr;
    logic [31:0] dataIn;
    logic        dataWe;
    logic        dataRe;
    logic [31:0] dataOut;
    logic        memValid;

    modport slave (
        input  pcIn, dataAddr, dataIn, dataWe, dataRe,
        output instrOut, ifValid, dataOut, memValid
    );

    modport master (
        output pcIn, dataAddr, dataIn, dataWe, dataRe,
        input  instrOut, ifValid, dataOut, memValid
    );

endinterface

// File: rtl/mem_responder_ram.sv
// Single-port read-first RAM with synchronous read; no reset so it maps onto one block RAM.
module SinglePortRam #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // rdata always returns the word as it was before any write in the same cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: round-robin arbiter serving a fetch port and a data port
// from one single-port RAM, with optional wait states before every access.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]            state;
    logic [3:0]            wait_cnt;
    logic                  last_data;
    req_t                  req;
    logic [ADDR_WIDTH-1:0] req_word;
    logic                  pend_valid;
    logic                  pend_port;
    logic                  pend_rd;

    logic                  data_pending;
    logic                  take_data;
    logic [31:0]           grant_addr;
    logic                  ram_en;
    logic                  ram_we;
    logic [31:0]           ram_rdata;
    logic                  unused_addr_bits;

    assign data_pending     = bus.dataRe | bus.dataWe;
    assign take_data        = grant_data(data_pending, last_data);
    assign grant_addr       = take_data ? bus.dataAddr : bus.pcIn;
    assign ram_en           = (state == ST_ACCESS) && !rst;
    assign ram_we           = ram_en && req.we;
    assign unused_addr_bits = ^{grant_addr[31:ADDR_WIDTH+2], grant_addr[1:0]};

    // Grant, wait and access sequencing; the request is frozen at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            last_data  <= PORT_DATA;
            req        <= '0;
            req_word   <= '0;
            pend_valid <= 1'b0;
            pend_port  <= PORT_FETCH;
            pend_rd    <= 1'b0;
        end else begin
            pend_valid <= (state == ST_ACCESS);
            pend_port  <= req.port;
            pend_rd    <= req.rd;
            case (state)
                ST_IDLE: begin
                    req.port  <= take_data ? PORT_DATA : PORT_FETCH;
                    req.we    <= take_data & bus.dataWe;
                    req.rd    <= take_data ? bus.dataRe : 1'b1;
                    req.wdata <= bus.dataIn;
                    req_word  <= grant_addr[ADDR_WIDTH+1:2];
                    last_data <= take_data;
                    if (WAIT_CYCLES > 0) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end else begin
                        state <= ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM read data lands one edge after ACCESS; route it to the granted port here.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ifValid  <= 1'b0;
            bus.memValid <= 1'b0;
            bus.instrOut <= 32'h0;
            bus.dataOut  <= 32'h0;
        end else begin
            bus.ifValid  <= pend_valid && (pend_port == PORT_FETCH);
            bus.memValid <= pend_valid && (pend_port == PORT_DATA);
            if (pend_valid && (pend_port == PORT_FETCH)) begin
                bus.instrOut <= ram_rdata;
            end
            if (pend_valid && (pend_port == PORT_DATA) && pend_rd) begin
                bus.dataOut <= ram_rdata;
            end
        end
    end

    SinglePortRam #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (req_word),
        .wdata(req.wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (WAIT_CYCLES 0, 2, 3) driven
// from a vector table plus hand-timed sequences for latency, fairness and abort.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst2, rst3;

    mem_responder_if bus0();
    mem_responder_if bus2();
    mem_responder_if bus3();

    mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));
    mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

    typedef struct {
        logic        fetch;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expOut;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_pc [4];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setReq(input int d, input logic we, input logic re, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc);
        case (d)
            0: begin
                bus0.dataWe = we; bus0.dataRe = re; bus0.dataAddr = addr;
                bus0.dataIn = wdata; bus0.pcIn = pc;
            end
            2: begin
                bus2.dataWe = we; bus2.dataRe = re; bus2.dataAddr = addr;
                bus2.dataIn = wdata; bus2.pcIn = pc;
            end
            default: begin
                bus3.dataWe = we; bus3.dataRe = re; bus3.dataAddr = addr;
                bus3.dataIn = wdata; bus3.pcIn = pc;
            end
        endcase
    endtask

    task automatic setRst(input int d, input logic v);
        case (d)
            0:       rst0 = v;
            2:       rst2 = v;
            default: rst3 = v;
        endcase
    endtask

    function automatic logic getIf(input int d);
        case (d)
            0:       return bus0.ifValid;
            2:       return bus2.ifValid;
            default: return bus3.ifValid;
        endcase
    endfunction

    function automatic logic getMem(input int d);
        case (d)
            0:       return bus0.memValid;
            2:       return bus2.memValid;
            default: return bus3.memValid;
        endcase
    endfunction

    function automatic logic [31:0] getInstr(input int d);
        case (d)
            0:       return bus0.instrOut;
            2:       return bus2.instrOut;
            default: return bus3.instrOut;
        endcase
    endfunction

    function automatic logic [31:0] getDout(input int d);
        case (d)
            0:       return bus0.dataOut;
            2:       return bus2.dataOut;
            default: return bus3.dataOut;
        endcase
    endfunction

    task automatic waitIf(input int d, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (getIf(d)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut%0d ifValid wait: got no pulse expected pulse within 40 cycles", d);
        end
    endtask

    task automatic waitMem(input int d, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (getMem(d)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut%0d memValid wait: got no pulse expected pulse within 40 cycles", d);
        end
    endtask

    // A fetch vector waits two ifValid pulses: the first may belong to a fetch granted before pcIn changed.
    task automatic applyStimulus(input int d, input vec_t v, input string name);
        bit ok;
        if (v.fetch) begin
            cur_pc[d] = v.addr;
            setReq(d, 1'b0, 1'b0, 32'h0, 32'h0, v.addr);
            waitIf(d, ok);
            if (ok) waitIf(d, ok);
            if (ok) checkOutput({name, " instrOut"}, getInstr(d), v.expOut);
        end else begin
            setReq(d, v.we, v.re, v.addr, v.wdata, cur_pc[d]);
            waitMem(d, ok);
            if (ok) begin
                checkOutput({name, " dataOut"}, getDout(d), v.expOut);
                checkOutput({name, " ifValid overlap"}, {31'b0, getIf(d)}, 32'h0);
            end
            setReq(d, 1'b0, 1'b0, 32'h0, 32'h0, cur_pc[d]);
        end
    endtask

    vec_t tbl [13];

    initial begin : main
        vec_t        v;
        bit          ok;
        int          ifAt;
        int          memAt;
        int          cnt;
        int          memCnt;
        logic [1:0]  ev [4];
        logic [1:0]  evExp [4];

        // fetch, we, re, addr, wdata, expected dataOut (data op) or instrOut (fetch)
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0013, 32'h0000_0000};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0013};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hDEAD_BEEF};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_0002, 32'h0000_0001};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0002};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0007, 32'h0000_0000, 32'h0000_0013};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'hFFFF_C004, 32'h0000_0000, 32'h0000_0013};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0000_3FFC, 32'hCAFE_F00D, 32'h0000_0013};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0000_3FFF, 32'h0000_0000, 32'hCAFE_F00D};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h0000_7FFC, 32'h0000_0000, 32'hCAFE_F00D};

        rst0 = 1'b1;
        rst2 = 1'b1;
        rst3 = 1'b1;
        for (int d = 0; d < 4; d++) cur_pc[d] = 32'h0;
        setReq(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        setReq(2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        setReq(3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);

        checkOutput("reset ifValid",  {31'b0, getIf(0)},  32'h0);
        checkOutput("reset memValid", {31'b0, getMem(0)}, 32'h0);
        checkOutput("reset instrOut", getInstr(0), 32'h0);
        checkOutput("reset dataOut",  getDout(0),  32'h0);

        rst0 = 1'b0;
        rst2 = 1'b0;
        rst3 = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(0, tbl[i], $sformatf("vec%0d", i));
        end

        // Fairness: dataRe held through reset release; fetch must win first, then strict alternation.
        evExp[0] = 2'd0; evExp[1] = 2'd1; evExp[2] = 2'd0; evExp[3] = 2'd1;
        for (int k = 0; k < 4; k++) ev[k] = 2'd3;
        setRst(0, 1'b1);
        setReq(0, 1'b0, 1'b1, 32'h10, 32'h0, cur_pc[0]);
        @(negedge clk);
        setRst(0, 1'b0);
        cnt = 0;
        for (int n = 0; n < 40 && cnt < 4; n++) begin
            @(negedge clk);
            if (getIf(0)) begin
                ev[cnt] = 2'd0;
                cnt++;
            end
            if (getMem(0)) begin
                if (cnt < 4) ev[cnt] = 2'd1;
                cnt++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("alternation grant%0d", k), {30'b0, ev[k]}, {30'b0, evExp[k]});
        end
        setReq(0, 1'b0, 1'b0, 32'h0, 32'h0, cur_pc[0]);

        // Fetch latency with no wait states; RAM[1] survives the reset.
        cur_pc[0] = 32'h4;
        setReq(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
        setRst(0, 1'b1);
        @(negedge clk);
        setRst(0, 1'b0);
        ifAt = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (getIf(0)) begin
                ifAt = n;
                break;
            end
        end
        checkOutput("w0 fetch latency", 32'(ifAt - 1), 32'd2);
        checkOutput("w0 fetch word", getInstr(0), 32'h0000_0013);

        // Three wait states: fetch granted first, data granted as it completes.
        v = '{1'b0, 1'b1, 1'b0, 32'h20, 32'h1234_5678, 32'h0};
        applyStimulus(3, v, "w3 store");
        setReq(3, 1'b0, 1'b1, 32'h20, 32'h0, cur_pc[3]);
        setRst(3, 1'b1);
        @(negedge clk);
        setRst(3, 1'b0);
        ifAt  = -1;
        memAt = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (getIf(3) && ifAt < 0) ifAt = n;
            if (getMem(3)) begin
                memAt = n;
                break;
            end
        end
        checkOutput("w3 fetch latency", 32'(ifAt - 1), 32'd5);
        checkOutput("w3 load latency", 32'(memAt - ifAt), 32'd5);
        checkOutput("w3 load dataOut", getDout(3), 32'h1234_5678);
        setReq(3, 1'b0, 1'b0, 32'h0, 32'h0, cur_pc[3]);

        // Two wait states: reset during the store's WAIT must drop the write and the pulse.
        v = '{1'b0, 1'b1, 1'b0, 32'h8, 32'h1111_1111, 32'h0};
        applyStimulus(2, v, "w2 store old");
        setReq(2, 1'b1, 1'b0, 32'h8, 32'h55AA_55AA, cur_pc[2]);
        waitIf(2, ok);
        setRst(2, 1'b1);
        setReq(2, 1'b0, 1'b0, 32'h0, 32'h0, cur_pc[2]);
        @(negedge clk);
        setRst(2, 1'b0);
        memCnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (getMem(2)) memCnt++;
        end
        checkOutput("w2 abort memValid count", 32'(memCnt), 32'd0);
        checkOutput("w2 abort dataOut", getDout(2), 32'h0);
        v = '{1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 32'h1111_1111};
        applyStimulus(2, v, "w2 load after abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 500000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
